poly_soundpath: RTL and testbench

POLY_SOUNDPATH -- requirements
Module: poly_soundpath

---
 rtl/soundpath_pkg.sv | 32 +++
 rtl/soundpath_voice.sv | 69 ++++++
 rtl/poly_soundpath.sv | 69 ++++++
 tb/tb_poly_soundpath.sv | 223 ++++++++++++++++++++++
 4 files changed

// File: rtl/soundpath_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : soundpath_pkg
//  Purpose  : Shared types and constants for the polyphonic sound path.
//             Provides the waveform-select enum, the noise LFSR seed and tap
//             positions, and a helper that advances the LFSR by one step.
//  Revision : 1.0 - initial release
// ============================================================================
package soundpath_pkg;

    typedef enum logic [1:0] {
        SQUARE = 2'd0,
        SAW    = 2'd1,
        TRI    = 2'd2,
        NOISE  = 2'd3
    } wave_mode_t;

    localparam logic [15:0] LFSR_SEED  = 16'hACE1;
    localparam int          LFSR_TAP_A = 15;
    localparam int          LFSR_TAP_B = 13;
    localparam int          LFSR_TAP_C = 12;
    localparam int          LFSR_TAP_D = 10;

    // Shift left, feedback from the four taps enters at bit 0.
    function automatic logic [15:0] lfsr_next(input logic [15:0] state);
        return {state[14:0],
                state[LFSR_TAP_A] ^ state[LFSR_TAP_B] ^
                state[LFSR_TAP_C] ^ state[LFSR_TAP_D]};
    endfunction

endpackage
`default_nettype wire

// File: rtl/soundpath_voice.sv
`default_nettype none
// ============================================================================
//  Module   : soundpath_voice
//  Purpose  : One oscillator voice: phase accumulator with retrigger on a
//             rising enable, noise LFSR clocked by accumulator wrap, and a
//             waveform selector. The output is forced to 0 while disabled.
//  Ports    : clk, n_rst (sync, active-low), enable, mode, inc -> wave
//  Revision : 1.0 - initial release
// ============================================================================
module soundpath_voice
    import soundpath_pkg::*;
#(
    parameter int SAMPLE_W = 8,
    parameter int ACC_W    = 24
) (
    input  logic                clk,
    input  logic                n_rst,
    input  logic                enable,
    input  wave_mode_t          mode,
    input  logic [ACC_W-1:0]    inc,
    output logic [SAMPLE_W-1:0] wave
);

    logic [ACC_W-1:0]    acc;
    logic [15:0]         lfsr;
    logic                enable_q;
    logic [ACC_W:0]      acc_sum;
    logic [SAMPLE_W-1:0] phase;
    logic [SAMPLE_W-1:0] tri_up;

    // Extra top bit of the sum is the wrap event that clocks the LFSR.
    assign acc_sum = {1'b0, acc} + {1'b0, inc};
    assign phase   = acc[ACC_W-1 -: SAMPLE_W];
    assign tri_up  = {phase[SAMPLE_W-2:0], 1'b0};

    always_ff @(posedge clk) begin
        if (!n_rst) begin
            acc      <= '0;
            lfsr     <= LFSR_SEED;
            enable_q <= 1'b0;
        end else begin
            enable_q <= enable;
            if (enable && !enable_q) begin
                // Retrigger: restart phase from zero, no increment this cycle.
                acc <= '0;
            end else if (enable) begin
                acc <= acc_sum[ACC_W-1:0];
                if (acc_sum[ACC_W]) begin
                    lfsr <= lfsr_next(lfsr);
                end
            end
        end
    end

    always_comb begin
        wave = '0;
        if (enable) begin
            unique case (mode)
                SQUARE:  wave = {SAMPLE_W{phase[SAMPLE_W-1]}};
                SAW:     wave = phase;
                TRI:     wave = phase[SAMPLE_W-1] ? ~tri_up : tri_up;
                NOISE:   wave = lfsr[15 -: SAMPLE_W];
                default: wave = '0;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: rtl/poly_soundpath.sv
`default_nettype none
// ============================================================================
//  Module   : poly_soundpath
//  Purpose  : Polyphonic sound path. NUM_VOICES oscillator voices are summed
//             and scaled by 1/NUM_VOICES into a registered output sample on
//             each sample_now strobe; done pulses when sample updates.
//  Ports    : clk, n_rst (sync, active-low), sample_now, enable[NV],
//             mode[2*NV], inc[ACC_W*NV] -> sample[SAMPLE_W], done
//  Revision : 1.0 - initial release
// ============================================================================
module poly_soundpath
    import soundpath_pkg::*;
#(
    parameter int NUM_VOICES = 4,
    parameter int SAMPLE_W   = 8,
    parameter int ACC_W      = 24
) (
    input  logic                        clk,
    input  logic                        n_rst,
    input  logic                        sample_now,
    input  logic [NUM_VOICES-1:0]       enable,
    input  logic [2*NUM_VOICES-1:0]     mode,
    input  logic [ACC_W*NUM_VOICES-1:0] inc,
    output logic [SAMPLE_W-1:0]         sample,
    output logic                        done
);

    localparam int LOG2_NV = $clog2(NUM_VOICES);
    localparam int SUM_W   = SAMPLE_W + LOG2_NV;

    logic [SAMPLE_W-1:0] wave [NUM_VOICES];
    logic [SUM_W-1:0]    mix_sum;

    for (genvar v = 0; v < NUM_VOICES; v++) begin : g_voice
        soundpath_voice #(
            .SAMPLE_W (SAMPLE_W),
            .ACC_W    (ACC_W)
        ) u_voice (
            .clk    (clk),
            .n_rst  (n_rst),
            .enable (enable[v]),
            .mode   (wave_mode_t'(mode[2*v +: 2])),
            .inc    (inc[ACC_W*v +: ACC_W]),
            .wave   (wave[v])
        );
    end

    // Sum is wide enough for every voice at full scale, so no saturation.
    always_comb begin
        mix_sum = '0;
        for (int v = 0; v < NUM_VOICES; v++) begin
            mix_sum = mix_sum + SUM_W'(wave[v]);
        end
    end

    always_ff @(posedge clk) begin
        if (!n_rst) begin
            sample <= '0;
            done   <= 1'b0;
        end else begin
            done <= sample_now;
            if (sample_now) begin
                sample <= SAMPLE_W'(mix_sum >> LOG2_NV);
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_poly_soundpath.sv
`default_nettype none
// ============================================================================
//  Module   : tb_poly_soundpath
//  Purpose  : Self-checking bench for poly_soundpath (4 voices, 8-bit sample,
//             24-bit accumulators) against a behavioural model of the voices.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_poly_soundpath;

    localparam int NV = 4;
    localparam int SW = 8;
    localparam int AW = 24;
    localparam longint ACC_MOD = 64'd1 << AW;

    logic            clk = 1'b0;
    logic            n_rst;
    logic            sample_now;
    logic [NV-1:0]   enable;
    logic [2*NV-1:0] mode;
    logic [AW*NV-1:0] inc;
    logic [SW-1:0]   sample;
    logic            done;

    always #5 clk = ~clk;

    poly_soundpath #(.NUM_VOICES(NV), .SAMPLE_W(SW), .ACC_W(AW)) dut (
        .clk        (clk),
        .n_rst      (n_rst),
        .sample_now (sample_now),
        .enable     (enable),
        .mode       (mode),
        .inc        (inc),
        .sample     (sample),
        .done       (done)
    );

    int tests = 0;
    int fails = 0;

    // Behavioural model state
    longint m_acc  [NV];
    int     m_lfsr [NV];
    bit     m_hist [NV];
    int     m_sample;
    bit     m_done;

    function automatic int wave_of(int md, longint acc, int l);
        int ph;
        ph = int'(acc / 65536) % 256;
        case (md)
            0:       return (ph >= 128) ? 255 : 0;
            1:       return ph;
            2:       return (ph < 128) ? ph * 2 : 255 - ((ph * 2) % 256);
            default: return (l / 256) % 256;
        endcase
    endfunction

    function automatic int lfsr_step(int l);
        int fb;
        fb = ((l >> 15) ^ (l >> 13) ^ (l >> 12) ^ (l >> 10)) & 1;
        return ((l * 2) + fb) % 65536;
    endfunction

    task automatic model_edge();
        int sum;
        longint s;
        if (!n_rst) begin
            for (int v = 0; v < NV; v++) begin
                m_acc[v] = 0; m_lfsr[v] = 'hACE1; m_hist[v] = 0;
            end
            m_sample = 0;
            m_done   = 0;
        end else begin
            sum = 0;
            for (int v = 0; v < NV; v++)
                if (enable[v]) sum += wave_of(int'(mode[2*v +: 2]), m_acc[v], m_lfsr[v]);
            m_done = sample_now;
            if (sample_now) m_sample = sum / NV;
            for (int v = 0; v < NV; v++) begin
                if (enable[v] && !m_hist[v]) begin
                    m_acc[v] = 0;
                end else if (enable[v]) begin
                    s = m_acc[v] + longint'(inc[AW*v +: AW]);
                    if (s >= ACC_MOD) m_lfsr[v] = lfsr_step(m_lfsr[v]);
                    m_acc[v] = s % ACC_MOD;
                end
                m_hist[v] = enable[v];
            end
        end
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic cycle();
        @(posedge clk);
        model_edge();
        #1;
        check("sample", 32'(sample), 32'(m_sample));
        check("done",   32'(done),   32'(m_done));
    endtask

    initial begin
        // Reset with sample_now high: must be ignored.
        n_rst = 1'b0; sample_now = 1'b1; enable = '0; mode = '0; inc = '0;
        cycle();
        check("reset_sample", 32'(sample), 32'd0);
        check("reset_done",   32'(done),   32'd0);
        n_rst = 1'b1; sample_now = 1'b0;
        cycle();

        // Saw on voice 0, 200 increments after retrigger -> 200>>2 = 50.
        mode = 8'b00_00_00_01;
        inc[0 +: AW] = 24'h010000;
        enable = 4'b0001;
        cycle();
        repeat (200) cycle();
        sample_now = 1'b1;
        cycle();
        check("saw_value", 32'(sample), 32'd50);
        check("saw_done",  32'(done),   32'd1);
        sample_now = 1'b0;
        cycle();
        check("saw_done_pulse", 32'(done), 32'd0);
        check("saw_hold",       32'(sample), 32'd50);

        // Square mix, all voices retriggered together, period 32 samples.
        enable = '0;
        cycle();
        mode = '0;
        for (int v = 0; v < NV; v++) inc[AW*v +: AW] = 24'h080000;
        enable = 4'b1111;
        cycle();
        sample_now = 1'b1;
        for (int k = 0; k < 40; k++) begin
            cycle();
            check("square_mix", 32'(sample), ((k % 32) < 16) ? 32'd0 : 32'd255);
        end
        sample_now = 1'b0;

        // Noise: clean LFSR after reset, one wrap -> 16'h59C3 -> sample 8'h16.
        n_rst = 1'b0; enable = '0;
        cycle();
        n_rst = 1'b1;
        mode = 8'b00_00_00_11;
        inc = '0;
        inc[0 +: AW] = 24'h800000;
        enable = 4'b0001;
        cycle();
        cycle();
        cycle();
        sample_now = 1'b1;
        cycle();
        check("noise_mix", 32'(sample), 32'h16);
        sample_now = 1'b0;

        // Hold and retrigger: disabled voice contributes 0, re-raise restarts saw.
        mode = 8'b00_00_00_01;
        inc[0 +: AW] = 24'h100000;
        repeat (5) cycle();
        enable = 4'b0000;
        sample_now = 1'b1;
        for (int k = 0; k < 10; k++) begin
            cycle();
            check("hold_zero", 32'(sample), 32'd0);
        end
        enable = 4'b0001;
        cycle();
        cycle();
        check("retrig_zero", 32'(sample), 32'd0);
        repeat (8) cycle();
        sample_now = 1'b0;

        // Mid-run reset during a 4-voice triangle run.
        enable = '0;
        cycle();
        mode = 8'b10_10_10_10;
        for (int v = 0; v < NV; v++) inc[AW*v +: AW] = 24'($urandom);
        enable = 4'b1111;
        for (int k = 0; k < 60; k++) begin
            sample_now = 1'($urandom);
            cycle();
        end
        n_rst = 1'b0; sample_now = 1'b1;
        repeat (3) begin
            cycle();
            check("midreset_done",   32'(done),   32'd0);
            check("midreset_sample", 32'(sample), 32'd0);
        end
        n_rst = 1'b1; sample_now = 1'b0;
        repeat (5) begin
            cycle();
            check("postreset_done", 32'(done), 32'd0);
        end
        sample_now = 1'b1;
        cycle();
        check("postreset_strobe", 32'(done), 32'd1);
        sample_now = 1'b0;

        // Randomised run against the model.
        for (int k = 0; k < 3000; k++) begin
            if (($urandom % 16) == 0) enable = 4'($urandom);
            if (($urandom % 8) == 0)  mode = 8'($urandom);
            if (($urandom % 12) == 0) begin
                for (int v = 0; v < NV; v++)
                    inc[AW*v +: AW] = (($urandom % 6) == 0) ? 24'd0 : 24'($urandom);
            end
            sample_now = 1'($urandom);
            n_rst = (($urandom % 300) == 0) ? 1'b0 : 1'b1;
            cycle();
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
`default_nettype wire
